bcd2bin_seq: RTL and testbench

//  Multi-cycle BCD-to-binary converter using reverse double-dabble (shift right, digit>=8 -> -3).

---
 rtl/bcd2bin_seq.sv | 118 +++++++++++
 tb/tb_bcd2bin_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd2bin_seq.sv
// Multi-cycle packed-BCD to unsigned binary converter (reverse double-dabble).
// One conversion at a time; start/busy/done handshake, err flags digits above 9.
module bcd2bin_seq #(
  parameter int DIGITS = 2,
  parameter int N      = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [N-1:0]          binary,
  output logic                  err
);

  localparam int DW = 4 * DIGITS;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_reg, state_next;
  logic [DW-1:0]   digit_reg, digit_next;
  logic [N-1:0]    result_reg, result_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [N-1:0]    binary_reg, binary_next;
  logic            err_reg, err_next;

  logic [DW+N-1:0] shifted;
  logic [DW-1:0]   digit_adj;
  logic [DIGITS-1:0] bad_digit;
  logic            any_bad;

  // Digit LSB falls into the result MSB as one concatenated shift.
  assign shifted = {digit_reg, result_reg} >> 1;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] d;
      assign d = shifted[N + 4*gi +: 4];
      assign digit_adj[4*gi +: 4] = (d >= 4'd8) ? (d - 4'd3) : d;
      assign bad_digit[gi] = (bcd_in[4*gi +: 4] > 4'd9);
    end
  endgenerate

  assign any_bad = |bad_digit;

  always_comb begin
    state_next  = state_reg;
    digit_next  = digit_reg;
    result_next = result_reg;
    count_next  = count_reg;
    binary_next = binary_reg;
    err_next    = err_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          digit_next  = bcd_in;
          result_next = '0;
          count_next  = '0;
          err_next    = 1'b0;
          if (any_bad) begin
            err_next    = 1'b1;
            binary_next = '0;
            state_next  = DONE;
          end else begin
            state_next  = SHIFT;
          end
        end
      end
      SHIFT: begin
        digit_next  = digit_adj;
        result_next = shifted[N-1:0];
        count_next  = count_reg + 1'b1;
        if (count_reg == CW'(N - 1)) begin
          binary_next = shifted[N-1:0];
          state_next  = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      digit_reg  <= '0;
      result_reg <= '0;
      count_reg  <= '0;
      binary_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      digit_reg  <= digit_next;
      result_reg <= result_next;
      count_reg  <= count_next;
      binary_reg <= binary_next;
      err_reg    <= err_next;
    end
  end

  // A valid input must have drained every digit into the result by the last step.
  always @(posedge clk) begin
    if (!reset && state_reg == SHIFT && count_reg == CW'(N - 1))
      assert (digit_adj == '0);
  end

  assign busy   = (state_reg == SHIFT);
  assign done   = (state_reg == DONE);
  assign binary = binary_reg;
  assign err    = err_reg;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Bench for bcd2bin_seq: directed cases, random and exhaustive conversions on a
// 2-digit and a 3-digit instance, checked against a decimal reference model.
module tb_bcd2bin_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        start_c;
  logic [11:0] bcd_c;

  logic        start2, busy2, done2, err2;
  logic [7:0]  bcd2;
  logic [6:0]  binary2;
  logic        start3, busy3, done3, err3;
  logic [11:0] bcd3;
  logic [9:0]  binary3;

  logic        busy_m, done_m, err_m;
  logic [9:0]  binary_m;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign start2   = start_c & ~sel;
  assign start3   = start_c & sel;
  assign bcd2     = bcd_c[7:0];
  assign bcd3     = bcd_c;
  assign busy_m   = sel ? busy3 : busy2;
  assign done_m   = sel ? done3 : done2;
  assign err_m    = sel ? err3 : err2;
  assign binary_m = sel ? binary3 : {3'b000, binary2};

  bcd2bin_seq #(.DIGITS(2), .N(7)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .bcd_in(bcd2),
    .busy(busy2), .done(done2), .binary(binary2), .err(err2)
  );

  bcd2bin_seq #(.DIGITS(3), .N(10)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .bcd_in(bcd3),
    .busy(busy3), .done(done3), .binary(binary3), .err(err3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Decimal interpretation of the packed digits; invalid digits give value 0.
  task automatic model(input logic [11:0] bcd, input int digits, output int val, output bit inval);
    val = 0;
    inval = 1'b0;
    for (int i = digits - 1; i >= 0; i--) begin
      int d;
      d = int'((bcd >> (4 * i)) & 12'hf);
      if (d > 9) inval = 1'b1;
      val = val * 10 + d;
    end
    if (inval) val = 0;
  endtask

  // Call at a negedge with the selected instance idle; returns at a negedge, idle.
  task automatic convert(input logic [11:0] bcd, input string tag);
    int  exp_val, n, cycles, busy_cnt;
    bit  exp_bad;
    n = sel ? 10 : 7;
    model(bcd, sel ? 3 : 2, exp_val, exp_bad);
    bcd_c   = bcd;
    start_c = 1'b1;
    @(negedge clk);
    start_c  = 1'b0;
    cycles   = 0;
    busy_cnt = 0;
    while (!done_m && cycles < 40) begin
      if (busy_m) busy_cnt++;
      @(negedge clk);
      cycles++;
    end
    check({tag, ".latency"}, cycles, exp_bad ? 0 : n);
    check({tag, ".busy_cycles"}, busy_cnt, exp_bad ? 0 : n);
    check({tag, ".binary"}, binary_m, exp_val);
    check({tag, ".err"}, err_m, exp_bad);
    $display("conv %s bcd=%h binary=%0d err=%0d cycles=%0d", tag, bcd, binary_m, err_m, cycles);
    @(negedge clk);
    check({tag, ".done_pulse"}, done_m, 0);
  endtask

  initial begin
    int cycles, done_cnt, busy_seen, prev, idx, exp_val;
    bit exp_bad;
    logic [11:0] vals [4];
    logic [11:0] r;

    reset   = 1'b1;
    sel     = 1'b0;
    start_c = 1'b0;
    bcd_c   = '0;
    repeat (3) @(negedge clk);
    check("rst.busy2", busy2, 0);
    check("rst.done2", done2, 0);
    check("rst.binary2", binary2, 0);
    check("rst.err2", err2, 0);
    check("rst.binary3", binary3, 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed 2-digit cases including invalid digit
    convert(12'h099, "d99");
    convert(12'h057, "d57");
    convert(12'h000, "d00");
    convert(12'h010, "d10");
    convert(12'h009, "d09");
    convert(12'h01A, "d1A");
    convert(12'h0A0, "dA0");
    convert(12'h042, "d42");

    // start re-presented during SHIFT and DONE must be ignored
    bcd_c   = 12'h042;
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    cycles  = 0;
    @(negedge clk); cycles++;
    @(negedge clk); cycles++;
    bcd_c   = 12'h077;
    start_c = 1'b1;
    @(negedge clk); cycles++;
    start_c = 1'b0;
    while (!done_m && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    check("ign.latency", cycles, 7);
    check("ign.binary", binary_m, 42);
    done_cnt  = done_m ? 1 : 0;
    busy_seen = 0;
    start_c   = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    repeat (15) begin
      if (done_m) done_cnt++;
      if (busy_m) busy_seen++;
      @(negedge clk);
    end
    check("ign.done_count", done_cnt, 1);
    check("ign.busy_after", busy_seen, 0);
    $display("conv ign bcd=042 binary=%0d done_count=%0d", binary_m, done_cnt);

    // Reset in the 3rd SHIFT cycle abandons the conversion
    bcd_c   = 12'h099;
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mrst.busy", busy_m, 0);
    check("mrst.done", done_m, 0);
    check("mrst.binary", binary_m, 0);
    check("mrst.err", err_m, 0);
    done_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_m || busy_m) done_cnt++;
    end
    check("mrst.quiet", done_cnt, 0);
    $display("conv mrst aborted, outputs cleared");
    convert(12'h064, "mrst.after");

    // Random 2-digit
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 3) == 0) r = 12'($urandom_range(0, 255));
      else r = {4'h0, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      convert(r, "rnd2");
    end

    // 3-digit instance
    sel = 1'b1;
    @(negedge clk);
    convert(12'h999, "t999");
    convert(12'h9F0, "t9F0");
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 3) == 0) r = 12'($urandom_range(0, 4095));
      else r = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      convert(r, "rnd3");
    end
    for (int v = 0; v < 1000; v++) begin
      r = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      convert(r, "sweep");
    end

    // start held high: one conversion per N+2 cycles
    vals[0] = 12'h999; vals[1] = 12'h123; vals[2] = 12'h500; vals[3] = 12'h007;
    bcd_c   = vals[0];
    start_c = 1'b1;
    prev    = 0;
    idx     = 0;
    cycles  = 0;
    while (idx < 4 && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (done_m) begin
        model(vals[idx], 3, exp_val, exp_bad);
        check("b2b.binary", binary_m, exp_val);
        if (idx > 0) check("b2b.period", cycles - prev, 12);
        $display("conv b2b bcd=%h binary=%0d at cycle %0d", vals[idx], binary_m, cycles);
        prev = cycles;
        idx++;
        if (idx < 4) bcd_c = vals[idx];
      end
    end
    start_c = 1'b0;
    check("b2b.count", idx, 4);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
